baudgen_nco: RTL and testbench
==============================

BAUDGEN_NCO -- requirements
Module: baudgen_nco

Interface
REQ-001 Parameter ACC_W, default 16: phase accumulator width in bits; legal range 8..32.
REQ-002 Parameter OVS, default 16: number of oversample ticks per bit; even, 2..256.
REQ-003 Parameter RESET_INCR, default 16'h0F1B: increment applied from reset, width ACC_W.
REQ-004 The block SHALL have port clock_in, input, 1 bit: positive edge-triggered system clock.
REQ-005 The block SHALL have port n_reset_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable_in, input, 1 bit: run when high; freeze all state when low.
REQ-007 The block SHALL have port incr_in, input, ACC_W bits: new phase increment; f_ovs = f_clk*incr/2^ACC_W.
REQ-008 The block SHALL have port load_in, input, 1 bit: one-cycle strobe that captures incr_in.
REQ-009 The block SHALL have port sync_in, input, 1 bit: one-cycle strobe that restarts the bit phase (RX start-edge realignment).
REQ-010 The block SHALL have port ovs_tick_out, output, 1 bit: one-cycle oversample tick.
REQ-011 The block SHALL have port mid_tick_out, output, 1 bit: one-cycle tick at the bit centre.
REQ-012 The block SHALL have port bit_tick_out, output, 1 bit: one-cycle tick at the bit boundary.
REQ-013 The block SHALL have port pending_out, output, 1 bit: a loaded increment is waiting to take effect.

Function
REQ-014 The block SHALL, on each clock edge with enable_in high, update acc <= acc + incr_active modulo 2^ACC_W, and register the carry-out into ovs_tick_out.
- Latency: one edge.
- ovs_tick_out is high for exactly one cycle per carry.
REQ-015 The block SHALL, when incr_active == 0, produce no ticks while holding acc constant.
REQ-016 The block SHALL maintain ovs_cnt, counting 0..OVS-1, that advances on each carry and wraps from OVS-1 to 0.
REQ-017 The block SHALL assert bit_tick_out in the same cycle as ovs_tick_out when the carry wrapped ovs_cnt from OVS-1 to 0.
REQ-018 The block SHALL assert mid_tick_out in the same cycle as ovs_tick_out when the carry moved ovs_cnt from OVS/2-1 to OVS/2.
REQ-019 The block SHALL, on load_in high, capture incr_in into incr_pending and set pending_out on the next edge.
- A later load before application overwrites incr_pending.
REQ-020 The block SHALL copy incr_pending to incr_active and clear pending_out on the edge that registers a bit_tick_out, so that rate changes occur only at bit boundaries.
REQ-021 The block SHALL, when enable_in is low or incr_active == 0, apply a pending increment on the next edge instead of waiting for a bit boundary.
REQ-022 The block SHALL, on sync_in high with enable_in high, set acc to 2^(ACC_W-1) and ovs_cnt to 0, and force all tick outputs to 0 on that edge.
- sync_in overrides any carry in the same cycle.
- A pending increment is applied on that same edge.
REQ-023 The block SHALL, with enable_in low, hold acc, ovs_cnt and incr_active, and drive all tick outputs to 0.
- Operation resumes from the held phase when enable_in returns high.
- load_in is still accepted while enable_in is low.
REQ-024 The block SHALL give load_in priority over pending-clear when both occur on the same edge: the new value becomes pending and pending_out stays 1.

Reset
REQ-025 The block SHALL, while n_reset_in is low (asynchronously), set:
- acc = 0, ovs_cnt = 0
- incr_active = RESET_INCR, incr_pending = RESET_INCR, pending_out = 0
- ovs_tick_out = mid_tick_out = bit_tick_out = 0
REQ-026 The block SHALL perform its first accumulation on the first edge after reset release, provided enable_in is high.

Structure
REQ-027 Package baudgen_pkg SHALL hold:
- default ACC_W and OVS constants
- constant increments for 9600, 115200 and 921600 baud at 50 MHz with OVS=16
- a constant function computing incr = round(baud*OVS*2^ACC_W / f_clk)
REQ-028 The phase accumulator and its carry register SHALL be a sub-module, baudgen_nco_acc.
- It is parametrised by ACC_W.
- Its ports are enable, sync, incr and carry.

Verification
REQ-029 ACC_W=16, OVS=16, incr=0x8000, enable high: ovs_tick_out after edges 2,4,6,…; mid_tick_out after edge 16; bit_tick_out after edge 32, then every 32 edges.
REQ-030 incr=0x1000, with load_in of 0x2000 in the middle of a bit: pending_out=1 until the bit_tick_out edge, then the ovs period changes from 16 to 8 cycles starting with the next tick.
REQ-031 sync_in pulsed one cycle after an ovs tick, incr=0x8000: no tick on the sync edge; next ovs_tick_out after exactly 1 edge (acc=0x8000+0x8000); ovs_cnt restarts so bit_tick_out follows 16 ticks later.
REQ-032 enable_in low for 10 cycles mid-bit: all ticks 0, with acc and ovs_cnt unchanged (checked through hierarchy); tick spacing continues without phase error after re-enable.
REQ-033 n_reset_in asserted mid-operation, asynchronous to the clock: outputs go to 0 immediately; after release, incr_active equals RESET_INCR.
REQ-034 incr=0 loaded while running: no ticks for 100 cycles; a subsequent load of 0x8000 takes effect on the next edge without waiting for a bit boundary.

Source files
------------

// File: rtl/baudgen_pkg.sv
// Shared constants for the baud-rate NCO: default geometry, the standard
// 50 MHz / 16x oversample increments, and the increment calculator.
// Ports: none (package).
package baudgen_pkg;

    localparam int ACC_W_DEF = 16;
    localparam int OVS_DEF   = 16;
    localparam longint unsigned F_CLK_HZ = 64'd50_000_000;

    // incr = round(baud * ovs * 2^acc_w / f_clk); 64-bit intermediate is wide
    // enough for acc_w = 32 with ovs = 256 at any realistic baud rate.
    function automatic logic [31:0] calc_incr(
        input longint unsigned baud,
        input longint unsigned ovs,
        input int unsigned     acc_w,
        input longint unsigned fclk
    );
        longint unsigned num;
        num = baud * ovs * (64'd1 << acc_w);
        return 32'((num + fclk / 64'd2) / fclk);
    endfunction

    localparam logic [ACC_W_DEF-1:0] INCR_9600 =
        ACC_W_DEF'(calc_incr(64'd9600, 64'(OVS_DEF), ACC_W_DEF, F_CLK_HZ));
    localparam logic [ACC_W_DEF-1:0] INCR_115200 =
        ACC_W_DEF'(calc_incr(64'd115200, 64'(OVS_DEF), ACC_W_DEF, F_CLK_HZ));
    localparam logic [ACC_W_DEF-1:0] INCR_921600 =
        ACC_W_DEF'(calc_incr(64'd921600, 64'(OVS_DEF), ACC_W_DEF, F_CLK_HZ));

endpackage

// File: rtl/baudgen_nco_acc.sv
// Phase accumulator with registered carry-out; carry is the oversample tick.
// Ports: clock_in/n_reset_in, enable (freeze when low), sync (jump to half
// phase, suppress carry), incr (phase step), carry (registered wrap flag).
module baudgen_nco_acc
    import baudgen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clock_in,
    input  logic             n_reset_in,
    input  logic             enable,
    input  logic             sync,
    input  logic [ACC_W-1:0] incr,
    output logic             carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, incr};

    // Carry is held (not cleared) while disabled so a tick that was due when
    // the block froze is still delivered on resume: no phase is lost.
    always_ff @(posedge clock_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (enable) begin
            if (sync) begin
                acc   <= {1'b1, {(ACC_W-1){1'b0}}};
                carry <= 1'b0;
            end else begin
                acc   <= sum[ACC_W-1:0];
                carry <= sum[ACC_W];
            end
        end
    end

endmodule

// File: rtl/baudgen_nco.sv
// Fractional baud generator: NCO oversample ticks, plus bit-centre and
// bit-boundary ticks decoded from an oversample counter.
// Ports: clock_in/n_reset_in, enable_in, incr_in+load_in (rate change,
// applied at a bit boundary), sync_in (restart bit phase), ovs/mid/bit ticks,
// pending_out (loaded rate not yet applied).
module baudgen_nco
    import baudgen_pkg::*;
#(
    parameter int               ACC_W      = ACC_W_DEF,
    parameter int               OVS        = OVS_DEF,
    parameter logic [ACC_W-1:0] RESET_INCR = ACC_W'(16'h0F1B)
) (
    input  logic             clock_in,
    input  logic             n_reset_in,
    input  logic             enable_in,
    input  logic [ACC_W-1:0] incr_in,
    input  logic             load_in,
    input  logic             sync_in,
    output logic             ovs_tick_out,
    output logic             mid_tick_out,
    output logic             bit_tick_out,
    output logic             pending_out
);

    localparam int CNT_W = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVS / 2 - 1);

    logic [CNT_W-1:0] ovs_cnt;
    logic [ACC_W-1:0] incr_active;
    logic [ACC_W-1:0] incr_pending;
    logic [ACC_W-1:0] incr_eff;
    logic             carry;
    logic             pending;
    logic             wrap_now;
    logic             apply;

    // ovs_cnt holds the count position of the tick currently on the carry
    // register; it commits the advance on the following edge.
    assign wrap_now = carry && (ovs_cnt == CNT_LAST);

    // A pending rate goes live at a bit boundary, on sync, or at once when
    // the NCO is stalled (disabled or zero rate) since no boundary would come.
    assign apply = pending &&
                   (!enable_in || sync_in || (incr_active == '0) || wrap_now);

    // Feed the new rate straight into the accumulation on the applying edge
    // so the first bit after the boundary already runs at the new rate.
    assign incr_eff = apply ? incr_pending : incr_active;

    baudgen_nco_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clock_in   (clock_in),
        .n_reset_in (n_reset_in),
        .enable     (enable_in),
        .sync       (sync_in),
        .incr       (incr_eff),
        .carry      (carry)
    );

    always_ff @(posedge clock_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            ovs_cnt      <= '0;
            incr_active  <= RESET_INCR;
            incr_pending <= RESET_INCR;
            pending      <= 1'b0;
        end else begin
            // A new load wins over the clear of a pending value.
            if (load_in) begin
                incr_pending <= incr_in;
                pending      <= 1'b1;
            end else if (apply) begin
                pending      <= 1'b0;
            end

            if (apply) begin
                incr_active <= incr_pending;
            end

            if (enable_in) begin
                if (sync_in) begin
                    ovs_cnt <= '0;
                end else if (carry) begin
                    ovs_cnt <= (ovs_cnt == CNT_LAST) ? '0 : ovs_cnt + 1'b1;
                end
            end
        end
    end

    assign ovs_tick_out = carry && enable_in;
    assign mid_tick_out = ovs_tick_out && (ovs_cnt == CNT_MID);
    assign bit_tick_out = ovs_tick_out && (ovs_cnt == CNT_LAST);
    assign pending_out  = pending;

endmodule

// File: tb/tb_baudgen_nco.sv
module tb_baudgen_nco;
    import baudgen_pkg::*;

    logic        clock_in;
    logic        n_reset_in;
    logic        enable_in;
    logic [15:0] incr_in;
    logic        load_in;
    logic        sync_in;
    logic        ovs_tick_out;
    logic        mid_tick_out;
    logic        bit_tick_out;
    logic        pending_out;

    int n_checks;
    int n_errors;

    baudgen_nco dut (
        .clock_in     (clock_in),
        .n_reset_in   (n_reset_in),
        .enable_in    (enable_in),
        .incr_in      (incr_in),
        .load_in      (load_in),
        .sync_in      (sync_in),
        .ovs_tick_out (ovs_tick_out),
        .mid_tick_out (mid_tick_out),
        .bit_tick_out (bit_tick_out),
        .pending_out  (pending_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle so outputs reflect that edge.
    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        n_reset_in = 1'b0;
        enable_in  = 1'b0;
        load_in    = 1'b0;
        sync_in    = 1'b0;
        incr_in    = 16'h0000;
        #7;
        @(negedge clock_in);
        n_reset_in = 1'b1;
    endtask

    // Load a rate while disabled (applies on the second edge), then enable.
    task automatic start_rate(input logic [15:0] v);
        enable_in = 1'b0;
        incr_in   = v;
        load_in   = 1'b1;
        step();
        load_in   = 1'b0;
        step();
        enable_in = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_reset_in = 1'b0;
        enable_in  = 1'b0;
        load_in    = 1'b0;
        sync_in    = 1'b0;
        incr_in    = 16'h0000;

        // ---- reset state and package constants
        #2;
        check("rst ovs", 32'(ovs_tick_out), 32'd0);
        check("rst mid", 32'(mid_tick_out), 32'd0);
        check("rst bit", 32'(bit_tick_out), 32'd0);
        check("rst pending", 32'(pending_out), 32'd0);
        check("pkg 9600", 32'(INCR_9600), 32'd201);
        check("pkg 115200", 32'(INCR_115200), 32'd2416);
        check("pkg 921600", 32'(INCR_921600), 32'd19327);
        @(negedge clock_in);
        n_reset_in = 1'b1;
        enable_in  = 1'b1;
        step();
        check("first accum acc", 32'(dut.u_acc.acc), 32'h0F1B);
        check("first accum incr_active", 32'(dut.incr_active), 32'h0F1B);

        // ---- load while disabled applies next edge; basic 0x8000 cadence
        do_reset();
        incr_in = 16'h8000;
        load_in = 1'b1;
        step();
        load_in = 1'b0;
        check("load pending set", 32'(pending_out), 32'd1);
        step();
        check("load pending clr", 32'(pending_out), 32'd0);
        check("load incr_active", 32'(dut.incr_active), 32'h8000);
        enable_in = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            step();
            check($sformatf("cad ovs e%0d", e), 32'(ovs_tick_out), 32'((e % 2) == 0));
            check($sformatf("cad mid e%0d", e), 32'(mid_tick_out), 32'((e % 32) == 16));
            check($sformatf("cad bit e%0d", e), 32'(bit_tick_out), 32'((e % 32) == 0));
        end

        // ---- rate change 0x1000 -> 0x2000 waits for the bit boundary
        do_reset();
        start_rate(16'h1000);
        for (int e = 1; e <= 280; e++) begin
            if (e == 100) begin
                incr_in = 16'h2000;
                load_in = 1'b1;
            end
            step();
            load_in = 1'b0;
            if (e <= 256)
                check($sformatf("rate ovs e%0d", e), 32'(ovs_tick_out), 32'((e % 16) == 0));
            else
                check($sformatf("rate ovs e%0d", e), 32'(ovs_tick_out), 32'(((e - 256) % 8) == 0));
            check($sformatf("rate mid e%0d", e), 32'(mid_tick_out), 32'(e == 128));
            check($sformatf("rate bit e%0d", e), 32'(bit_tick_out), 32'(e == 256));
            if (e != 256)
                check($sformatf("rate pend e%0d", e), 32'(pending_out), 32'(e >= 100 && e <= 255));
        end

        // ---- sync one cycle after a tick
        do_reset();
        start_rate(16'h8000);
        for (int e = 1; e <= 11; e++) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("sync no tick", 32'(ovs_tick_out), 32'd0);
        check("sync acc", 32'(dut.u_acc.acc), 32'h8000);
        check("sync cnt", 32'(dut.ovs_cnt), 32'd0);
        for (int e = 13; e <= 45; e++) begin
            step();
            check($sformatf("sync ovs e%0d", e), 32'(ovs_tick_out), 32'(((e - 13) % 2) == 0));
            check($sformatf("sync mid e%0d", e), 32'(mid_tick_out), 32'(e == 27));
            check($sformatf("sync bit e%0d", e), 32'(bit_tick_out), 32'(e == 43));
        end

        // ---- freeze for 10 cycles while a tick is showing
        do_reset();
        start_rate(16'h8000);
        for (int e = 1; e <= 20; e++) step();
        check("frz pre tick", 32'(ovs_tick_out), 32'd1);
        enable_in = 1'b0;
        #1;
        check("frz tick gated", 32'(ovs_tick_out), 32'd0);
        for (int d = 1; d <= 10; d++) begin
            step();
            check($sformatf("frz ticks d%0d", d), {29'd0, ovs_tick_out, mid_tick_out, bit_tick_out}, 32'd0);
        end
        check("frz acc", 32'(dut.u_acc.acc), 32'h0000);
        check("frz cnt", 32'(dut.ovs_cnt), 32'd9);
        enable_in = 1'b1;
        #1;
        check("frz resume tick", 32'(ovs_tick_out), 32'd1);
        for (int r = 1; r <= 14; r++) begin
            step();
            check($sformatf("frz ovs r%0d", r), 32'(ovs_tick_out), 32'((r % 2) == 0));
            check($sformatf("frz bit r%0d", r), 32'(bit_tick_out), 32'(r == 12));
        end

        // ---- asynchronous reset mid-operation
        do_reset();
        start_rate(16'h8000);
        for (int e = 1; e <= 20; e++) step();
        incr_in = 16'h1234;
        load_in = 1'b1;
        step();
        load_in = 1'b0;
        step();
        check("arst pre tick", 32'(ovs_tick_out), 32'd1);
        check("arst pre pend", 32'(pending_out), 32'd1);
        #2;
        n_reset_in = 1'b0;
        #1;
        check("arst ovs", 32'(ovs_tick_out), 32'd0);
        check("arst pend", 32'(pending_out), 32'd0);
        check("arst acc", 32'(dut.u_acc.acc), 32'h0000);
        @(negedge clock_in);
        n_reset_in = 1'b1;
        step();
        check("arst incr_active", 32'(dut.incr_active), 32'h0F1B);
        check("arst incr_pending", 32'(dut.incr_pending), 32'h0F1B);

        // ---- zero rate silences the NCO; next load applies immediately
        do_reset();
        start_rate(16'h8000);
        for (int e = 1; e <= 33; e++) begin
            if (e == 5) begin
                incr_in = 16'h0000;
                load_in = 1'b1;
            end
            step();
            load_in = 1'b0;
            if (e == 32) check("zero bit e32", 32'(bit_tick_out), 32'd1);
        end
        check("zero pend clr", 32'(pending_out), 32'd0);
        check("zero incr_active", 32'(dut.incr_active), 32'h0000);
        for (int e = 1; e <= 100; e++) begin
            step();
            check($sformatf("zero ticks e%0d", e), {29'd0, ovs_tick_out, mid_tick_out, bit_tick_out}, 32'd0);
        end
        incr_in = 16'h8000;
        load_in = 1'b1;
        step();
        load_in = 1'b0;
        check("zero reload pend", 32'(pending_out), 32'd1);
        step();
        check("zero reload pend clr", 32'(pending_out), 32'd0);
        check("zero reload incr", 32'(dut.incr_active), 32'h8000);
        check("zero reload acc", 32'(dut.u_acc.acc), 32'h8000);
        step();
        check("zero reload tick", 32'(ovs_tick_out), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
